// File: rtl/mem_responder.sv
// Multi-cycle word-addressed memory responder with fixed read latency.
// Optional 4-beat burst reads are enabled by defining MEM_BURST_EN.
module mem_responder #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int DEPTH_W = 10,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
`ifdef MEM_BURST_EN
    input  logic              burst,
    output logic [1:0]        beat,
`endif
    output logic              ready,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
`ifdef MEM_BURST_EN
        , BURST
`endif
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [DATA_W-1:0]  mem [2**DEPTH_W];
    state_t             state, state_n;
    logic [3:0]         cnt, cnt_n;
    logic [DEPTH_W-1:0] idx_q, idx_n, rd_idx;
    logic               accept, rd_start;
    logic               unused_addr;

`ifdef MEM_BURST_EN
    logic               bq, bq_n;
    logic [1:0]         beat_q, beat_n;
    logic               last_beat;

    assign last_beat  = (state == BURST) && (beat_q == 2'd3);
    assign ready      = (state == IDLE) || (state == RESP) || last_beat;
    assign data_valid = (state == RESP) || (state == BURST);
    assign beat       = (state == BURST) ? beat_q : 2'd0;
    assign rd_idx     = (state == BURST) ? {idx_q[DEPTH_W-1:2], beat_q} : idx_q;
`else
    assign ready      = (state == IDLE) || (state == RESP);
    assign data_valid = (state == RESP);
    assign rd_idx     = idx_q;
`endif

    assign accept      = enable & ready;
    assign rd_start    = accept & ~wr;
    assign data_out    = data_valid ? mem[rd_idx] : '0;
    assign unused_addr = ^{addr[ADDR_W-1:DEPTH_W+1], addr[0]};

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx_q;
`ifdef MEM_BURST_EN
        bq_n    = bq;
        beat_n  = beat_q;
`endif
        case (state)
            IDLE: state_n = IDLE;
            WAIT: begin
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd1) begin
`ifdef MEM_BURST_EN
                    state_n = bq ? BURST : RESP;
`else
                    state_n = RESP;
`endif
                end
            end
            RESP: state_n = IDLE;
`ifdef MEM_BURST_EN
            BURST: begin
                if (beat_q == 2'd3) state_n = IDLE;
                else                beat_n  = beat_q + 2'd1;
            end
`endif
            default: state_n = IDLE;
        endcase

        // A read accepted in RESP (or the last beat) restarts immediately
        if (rd_start) begin
            idx_n   = addr[DEPTH_W:1];
            cnt_n   = CNT_INIT;
            state_n = (LATENCY == 1) ? RESP : WAIT;
`ifdef MEM_BURST_EN
            bq_n   = burst;
            beat_n = 2'd0;
            if (burst) begin
                idx_n[1:0] = 2'b00;
                if (LATENCY == 1) state_n = BURST;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            idx_q  <= '0;
`ifdef MEM_BURST_EN
            bq     <= 1'b0;
            beat_q <= 2'd0;
`endif
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            idx_q  <= idx_n;
`ifdef MEM_BURST_EN
            bq     <= bq_n;
            beat_q <= beat_n;
`endif
        end
    end

    // Array is never cleared; reset only blocks a coincident write
    always_ff @(posedge clk) begin
        if (!rst && accept && wr)
            mem[addr[DEPTH_W:1]] <= data_in;
    end

endmodule
